minimax_mem_arbiter: RTL and testbench
======================================

// Module: minimax_mem_arbiter
// PURPOSE
//   Sits between the minimax core and NBANKS single-ported 512x32 SRAM macros.
//   Arbitrates the core's instruction-fetch and data ports onto one SRAM port.
//   Owns the instruction latch/register and the exit mailbox at 0xFFFFFFFC.
//   Performs read-modify-write for sub-word stores, since the macros have whole-word write enable only.
// PARAMETERS
//   PC_BITS   13  byte-address width of the RAM window (2**PC_BITS bytes)
//   NBANKS     4  SRAM macros; 512 words each; NBANKS*2048 == 2**PC_BITS
//   EXIT_ADDR 32'hFFFFFFFC  store address that reports test/firmware exit
// PORTS
//   clk         in   1           core clock; SRAM macros run on the same clk
//   reset       in   1           asynchronous, active-low (0 = in reset)
//   inst_addr   in   PC_BITS     core fetch address (halfword aligned)
//   inst_regce  in   1           core enable for the instruction register
//   inst        out  16          registered instruction to core
//   addr        in   32          core data address
//   wdata       in   32          core store data
//   wmask       in   4           byte-lane store mask; 0 = no store
//   rreq        in   1           core load request
//   rdata       out  32          load data, valid the cycle after the load is accepted
//   busy        out  1           core must hold all data-port inputs (RMW in progress)
//   sram_en     out  NBANKS      one-hot bank select
//   sram_addr   out  9           word index within bank
//   sram_wdata  out  32          write data to all banks
//   sram_wen    out  1           whole-word write strobe
//   sram_rdata  in   NBANKS*32   concatenated bank read data, 1-cycle synchronous read
//   exit_valid  out  1           one-cycle pulse on a store to EXIT_ADDR
//   exit_code   out  32          wdata captured with exit_valid; held until the next exit
// BEHAVIOUR
//   Reset: inst=0, rdata=0, busy=0, sram_en=0, sram_wen=0, exit_valid=0, exit_code=0, FSM=IDLE.
//   Priority per cycle in IDLE: store > load > fetch. Exactly one SRAM access per cycle.
//   Bank select: addr[PC_BITS-1:11]; word index: addr[10:2].
//   In range: addr[31:PC_BITS]==0. Out-of-range loads return 0. Out-of-range stores are dropped.
//   Full store (wmask==4'hF, in range): sram_wen=1 that cycle; rdata=0 next cycle; latch capture suppressed.
//   Partial store (wmask!=0, !=F): IDLE->RMW_RD (issue read, busy=1) ->RMW_WR.
//     In RMW_WR, merge the read word with wdata per byte lane, assert sram_wen; busy=1 in both states.
//     Return to IDLE; the core sees 2 busy cycles.
//   Load: issue read; next cycle rdata = selected bank word; rdata=0 on every cycle with no load result.
//   Fetch: issue read at inst_addr when no data access.
//     Next cycle the latch takes halfword [31:16] if the registered inst_addr[1]=1, else [15:0].
//     The latch is zeroed when a data access displaced the fetch.
//   inst register <= latch when inst_regce=1, else holds.
//   Store to EXIT_ADDR (any wmask!=0): exit_valid=1 next cycle, exit_code<=wdata, no SRAM access.
//   Simultaneous rreq and wmask!=0 is illegal; the store wins and the load is dropped.
//   Reset asserted mid-RMW: FSM->IDLE immediately, the pending write is abandoned, and SRAM is untouched.
//   Address wrap: the last word of bank NBANKS-1 has no wrap; the fetch at 2**PC_BITS-2 reads [31:16] of that word.
// STRUCTURE
//   Shared package minimax_pkg: FSM state enum {IDLE,RMW_RD,RMW_WR}, EXIT_ADDR constant, SRAM_WORDS=512.
//   One sub-module, minimax_bank_mux: one-hot sram_en decode plus AND-OR read-data select.
//   Arbitration, latch, RMW FSM and mailbox stay in this module.
// TESTING
//   1. Preload 0x12345678 at byte 0x10; fetch inst_addr=0x10 then 0x12, inst_regce=1
//      -> inst=0x5678 then 0x1234, 2-cycle latency.
//   2. Store wmask=F, addr=0x800, wdata=0xDEADBEEF, then rreq at 0x800
//      -> bank1 word0 written; rdata=0xDEADBEEF one cycle after rreq.
//   3. Word 0x11223344 at 0x20; store wmask=4'b0010, wdata=0x0000AA00
//      -> busy high 2 cycles; word becomes 0x1122AA44.
//   4. Fetch pending while rreq at 0x40 -> fetch displaced; latch=0 that cycle; load data returned.
//   5. Store 0 to 0xFFFFFFFC -> exit_valid pulse, exit_code=0; SRAM sram_wen stays 0.
//   6. Drop reset low during RMW_RD -> busy=0 and outputs at reset values; target word unchanged.

Source files
------------

// File: rtl/minimax_pkg.sv
// minimax_pkg: shared FSM states, constants and byte-lane merge helper for the memory arbiter
package minimax_pkg;
  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_e;
  localparam logic [31:0] EXIT_ADDR = 32'hFFFF_FFFC;
  localparam int SRAM_WORDS = 512;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] mask);
    for (int b = 0; b < 4; b++) byte_merge[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
  endfunction
endpackage

// File: rtl/minimax_bank_mux.sv
// minimax_bank_mux: one-hot SRAM bank enable decode and AND-OR read-data select
module minimax_bank_mux #(
  parameter int NBANKS = 4,
  parameter int BW     = 2
) (
  input  logic                 i_en,
  input  logic [BW-1:0]        i_wbank,
  input  logic [BW-1:0]        i_rbank,
  input  logic [NBANKS*32-1:0] i_sram_rdata,
  output logic [NBANKS-1:0]    o_sram_en,
  output logic [31:0]          o_word
);
  always_comb begin
    o_sram_en = '0;
    o_word    = '0;
    for (int b = 0; b < NBANKS; b++) begin
      o_sram_en[b] = i_en && (i_wbank == BW'(b));
      o_word       = o_word | (i_sram_rdata[32*b +: 32] & {32{i_rbank == BW'(b)}});
    end
  end
endmodule

// File: rtl/minimax_mem_arbiter.sv
// minimax_mem_arbiter: arbitrates core fetch and data ports onto banked single-port SRAM,
// owns the instruction register, the exit mailbox and read-modify-write for sub-word stores.
module minimax_mem_arbiter #(
  parameter int          PC_BITS   = 13,
  parameter int          NBANKS    = 4,
  parameter logic [31:0] EXIT_ADDR = minimax_pkg::EXIT_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [PC_BITS-1:0]   i_inst_addr,
  input  logic                 i_inst_regce,
  output logic [15:0]          o_inst,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wmask,
  input  logic                 i_rreq,
  output logic [31:0]          o_rdata,
  output logic                 o_busy,
  output logic [NBANKS-1:0]    o_sram_en,
  output logic [8:0]           o_sram_addr,
  output logic [31:0]          o_sram_wdata,
  output logic                 o_sram_wen,
  input  logic [NBANKS*32-1:0] i_sram_rdata,
  output logic                 o_exit_valid,
  output logic [31:0]          o_exit_code
);
  import minimax_pkg::*;
  localparam int WBITS = $clog2(SRAM_WORDS);
  localparam int BW    = PC_BITS - WBITS - 2;
  state_e             r_state;
  logic [PC_BITS-1:0] r_rmw_addr, w_a;
  logic [31:0]        r_rmw_wdata, r_exit_code, w_word;
  logic [3:0]         r_rmw_mask;
  logic [BW-1:0]      r_rbank;
  logic [15:0]        r_inst, w_latch;
  logic               r_ld_v, r_f_v, r_ia1, r_exit_valid;
  logic               w_idle, w_st, w_in, w_full, w_part, w_ld, w_fetch, w_exit, w_acc, w_unused;
  always_comb begin
    w_idle  = r_state == IDLE;
    w_st    = |i_wmask;
    w_in    = i_addr[31:PC_BITS] == '0;
    w_full  = w_idle && w_st && w_in && (&i_wmask);
    w_part  = w_idle && w_st && w_in && !(&i_wmask);
    w_ld    = w_idle && !w_st && i_rreq && w_in;
    w_fetch = w_idle && !w_st && !i_rreq;
    w_exit  = w_idle && w_st && (i_addr == EXIT_ADDR);
    w_a     = !w_idle ? r_rmw_addr : w_fetch ? i_inst_addr : i_addr[PC_BITS-1:0];
    w_acc   = i_rst_n && (w_full || w_ld || w_fetch || !w_idle);
    w_latch = !r_f_v ? 16'h0 : r_ia1 ? w_word[31:16] : w_word[15:0];
  end
  minimax_bank_mux #(.NBANKS(NBANKS), .BW(BW)) u_bank_mux (
    .i_en        (w_acc),
    .i_wbank     (w_a[PC_BITS-1:WBITS+2]),
    .i_rbank     (r_rbank),
    .i_sram_rdata(i_sram_rdata),
    .o_sram_en   (o_sram_en),
    .o_word      (w_word)
  );
  assign o_sram_addr  = w_a[WBITS+1:2];
  assign o_sram_wen   = i_rst_n && (w_full || r_state == RMW_WR);
  assign o_sram_wdata = r_state == RMW_WR ? byte_merge(w_word, r_rmw_wdata, r_rmw_mask) : i_wdata;
  assign o_busy       = !w_idle;
  assign o_rdata      = r_ld_v ? w_word : 32'h0;
  assign o_inst       = r_inst;
  assign o_exit_valid = r_exit_valid;
  assign o_exit_code  = r_exit_code;
  assign w_unused     = ^w_a[1:0];
  // Sub-word stores are captured so the RMW completes even if the core drops its request
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rmw_addr   <= '0;
      r_rmw_wdata  <= '0;
      r_rmw_mask   <= '0;
      r_rbank      <= '0;
      r_ld_v       <= 1'b0;
      r_f_v        <= 1'b0;
      r_ia1        <= 1'b0;
      r_inst       <= '0;
      r_exit_valid <= 1'b0;
      r_exit_code  <= '0;
    end else begin
      r_state      <= w_part ? RMW_RD : r_state == RMW_RD ? RMW_WR : IDLE;
      if (w_part) begin
        r_rmw_addr  <= i_addr[PC_BITS-1:0];
        r_rmw_wdata <= i_wdata;
        r_rmw_mask  <= i_wmask;
      end
      r_rbank      <= w_a[PC_BITS-1:WBITS+2];
      r_ld_v       <= w_ld;
      r_f_v        <= w_fetch;
      r_ia1        <= i_inst_addr[1];
      if (i_inst_regce) r_inst <= w_latch;
      r_exit_valid <= w_exit;
      if (w_exit) r_exit_code <= i_wdata;
    end
endmodule

// File: tb/tb_minimax_mem_arbiter.sv
// tb_minimax_mem_arbiter: directed and random checks of the arbiter against a flat word-array model
module tb_minimax_mem_arbiter;
  localparam int NB = 4;
  logic           clk = 1'b0, rst_n = 1'b0;
  logic [12:0]    inst_addr = '0;
  logic           regce = 1'b0, rreq = 1'b0;
  logic [15:0]    inst;
  logic [31:0]    addr = '0, wdata = '0, rdata, sram_wdata, exit_code;
  logic [3:0]     wmask = '0;
  logic           busy, sram_wen, exit_valid;
  logic [NB-1:0]  sram_en;
  logic [8:0]     sram_addr;
  logic [NB*32-1:0] sram_rdata;
  logic [31:0]    sram [NB][512];
  logic [31:0]    sram_q [NB];
  logic [31:0]    ref_mem [2048];
  logic [31:0]    exp_code = '0;
  int             checks = 0, errors = 0;

  always #5 clk = ~clk;

  minimax_mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_addr(inst_addr), .i_inst_regce(regce), .o_inst(inst),
    .i_addr(addr), .i_wdata(wdata), .i_wmask(wmask), .i_rreq(rreq), .o_rdata(rdata), .o_busy(busy),
    .o_sram_en(sram_en), .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_wen(sram_wen),
    .i_sram_rdata(sram_rdata), .o_exit_valid(exit_valid), .o_exit_code(exit_code)
  );

  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (sram_en[b]) begin
        if (sram_wen) sram[b][sram_addr] <= sram_wdata;
        sram_q[b] <= sram[b][sram_addr];
      end
  always_comb
    for (int b = 0; b < NB; b++) sram_rdata[32*b +: 32] = sram_q[b];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic in_r = a[31:13] == 0;
    logic ex = (a == 32'hFFFF_FFFC) && (m != 0);
    addr = a; wdata = d; wmask = m; rreq = 1'b0;
    #1;
    chk("store_wen", 32'(sram_wen), 32'(in_r && m == 4'hF));
    chk("store_en", 32'(sram_en), (in_r && m == 4'hF) ? 32'(1) << a[12:11] : 32'h0);
    tick();
    wmask = '0;
    if (ex) exp_code = d;
    chk("exit_valid", 32'(exit_valid), 32'(ex));
    chk("exit_code", exit_code, exp_code);
    if (in_r && m != 4'hF) begin
      chk("rmw_busy1", 32'(busy), 32'h1);
      tick();
      chk("rmw_busy2", 32'(busy), 32'h1);
      tick();
    end
    chk("busy_done", 32'(busy), 32'h0);
    if (in_r)
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a[12:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic load(input logic [31:0] a);
    addr = a; rreq = 1'b1; wmask = '0;
    tick();
    rreq = 1'b0;
    chk("load_rdata", rdata, (a[31:13] == 0) ? ref_mem[a[12:2]] : 32'h0);
    tick();
    chk("rdata_idle", rdata, 32'h0);
  endtask

  task automatic fetch(input logic [12:0] ia);
    logic [31:0] w = ref_mem[ia[12:2]];
    inst_addr = ia; regce = 1'b1;
    tick();
    tick();
    chk("inst", {16'h0, inst}, {16'h0, ia[1] ? w[31:16] : w[15:0]});
    regce = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_inst", {16'h0, inst}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_en", 32'(sram_en), 32'h0);
    chk("rst_wen", 32'(sram_wen), 32'h0);
    chk("rst_exit_valid", 32'(exit_valid), 32'h0);
    chk("rst_exit_code", exit_code, 32'h0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2048; i++) store(32'(i) << 2, $urandom, 4'hF);
    store(32'h10, 32'h1234_5678, 4'hF);
    fetch(13'h10);
    fetch(13'h12);
    store(32'h800, 32'hDEAD_BEEF, 4'hF);
    load(32'h800);
    store(32'h20, 32'h1122_3344, 4'hF);
    store(32'h20, 32'h0000_AA00, 4'b0010);
    load(32'h20);
    store(32'h40, 32'hA5A5_0F0F, 4'hF);
    inst_addr = 13'h10; regce = 1'b1; addr = 32'h40; rreq = 1'b1;
    tick();
    rreq = 1'b0;
    chk("displaced_load", rdata, ref_mem[16]);
    tick();
    chk("displaced_inst", {16'h0, inst}, 32'h0);
    regce = 1'b0;
    store(32'hFFFF_FFFC, 32'hCAFE_1234, 4'b0011);
    store(32'hFFFF_FFFC, 32'h0, 4'hF);
    store(32'h0000_1FFC, 32'hBEEF_0123, 4'hF);
    fetch(13'h1FFE);
    load(32'h0000_2010);
    store(32'h0000_2010, 32'h5555_5555, 4'hF);
    load(32'h10);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = {19'h0, 11'($urandom), 2'b00};
      logic [31:0] oob = a | (32'h2000 << $urandom_range(0, 18));
      case ($urandom_range(0, 5))
        0: store(a, $urandom, 4'hF);
        1: store(a, $urandom, 4'($urandom_range(1, 14)));
        2: load(a);
        3: fetch(13'($urandom) & 13'h1FFE);
        4: load(oob);
        default: store(oob, $urandom, 4'($urandom_range(1, 15)));
      endcase
    end
    store(32'h60, 32'h7788_99AA, 4'hF);
    addr = 32'h60; wdata = 32'hFFFF_FFFF; wmask = 4'b0001;
    tick();
    wmask = '0;
    chk("rmw_rd_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    exp_code = '0;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_en", 32'(sram_en), 32'h0);
    chk("mid_rst_wen", 32'(sram_wen), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_inst", {16'h0, inst}, 32'h0);
    chk("mid_rst_exit_code", exit_code, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load(32'h60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
